// File: rtl/if_fetch_pkg.sv
// Shared CPU definitions for the MIPS31 fetch front end: FSM encoding and reset PC.
package if_fetch_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } fetch_state_e;

  // DROP still owns a memory request: it must run to completion before the new PC is fetched.
  function automatic logic is_requesting(fetch_state_e s);
    return (s == REQ) || (s == DROP);
  endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Fetch-unit bundle: PC/incrementer loop, redirect, imem req/ack bus and decode valid/ready bus.
interface if_fetch_if;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  modport master (
    output pc, imem_req, imem_addr, inst_valid, inst, inst_pc,
    input  pc_plus4, redirect_valid, redirect_pc, imem_ack, imem_rdata, inst_ready
  );

  modport slave (
    input  pc, imem_req, imem_addr, inst_valid, inst, inst_pc,
    output pc_plus4, redirect_valid, redirect_pc, imem_ack, imem_rdata, inst_ready
  );
endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch front end: one outstanding imem fetch at a time, one buffered instruction
// toward decode, redirects take effect without abandoning an in-flight memory request.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  if_fetch_if.master  bus
);

  fetch_state_e state;
  logic [31:0]  pc_q;
  logic [31:0]  addr_q;
  logic [31:0]  inst_q;
  logic [31:0]  inst_pc_q;

  // NOTE: handshake outputs decode only the state register, so no input reaches them combinationally.
  assign bus.imem_req   = is_requesting(state);
  assign bus.inst_valid = (state == HOLD);
  assign bus.pc         = pc_q;
  assign bus.imem_addr  = addr_q;
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;

  // NOTE: all state uses non-blocking assignment so every branch sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pc_q      <= RESET_PC;
      addr_q    <= RESET_PC;
      inst_q    <= '0;
      inst_pc_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          state <= REQ;
          if (bus.redirect_valid) begin
            pc_q   <= bus.redirect_pc;
            addr_q <= bus.redirect_pc;
          end
        end

        REQ: begin
          if (bus.imem_ack && !bus.redirect_valid) begin
            inst_q    <= bus.imem_rdata;
            inst_pc_q <= addr_q;
            pc_q      <= bus.pc_plus4;
            state     <= HOLD;
          end else if (bus.imem_ack) begin
            // Word already returned is stale; re-fetch from the target immediately.
            pc_q   <= bus.redirect_pc;
            addr_q <= bus.redirect_pc;
          end else if (bus.redirect_valid) begin
            pc_q  <= bus.redirect_pc;
            state <= DROP;
          end
        end

        DROP: begin
          if (bus.imem_ack) begin
            state <= REQ;
            if (bus.redirect_valid) begin
              pc_q   <= bus.redirect_pc;
              addr_q <= bus.redirect_pc;
            end else begin
              addr_q <= pc_q;
            end
          end else if (bus.redirect_valid) begin
            pc_q <= bus.redirect_pc;
          end
        end

        HOLD: begin
          if (bus.redirect_valid) begin
            pc_q   <= bus.redirect_pc;
            addr_q <= bus.redirect_pc;
            state  <= REQ;
          end else if (bus.inst_ready) begin
            addr_q <= pc_q;
            state  <= REQ;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
